// File: rtl/t07_mmio_responder.sv
// t07_mmio_responder: target side of the MMIO request/busy handshake.
// A request seen in IDLE is latched and served from a local word-addressed
// SRAM. busy_o stays high for LATENCY cycles. One DONE holdoff cycle follows,
// during which the initiator still drives its old request. Reads return
// right-justified, zero-extended byte, half or word data.
// Optional feature: define T07_MMIO_STATS_EN to build saturating counters of
// completed reads and writes. When it is not defined, both counters read 0.
module t07_mmio_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  rwi_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        busy_o,
    output logic        error_o,
    output logic [15:0] rd_count_o,
    output logic [15:0] wr_count_o
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam int          CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

    localparam logic [1:0] RWI_IDLE  = 2'b00;
    localparam logic [1:0] RWI_WRITE = 2'b01;
    localparam logic [1:0] RWI_FETCH = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          error_q, error_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          load;

    // Latched copy of the request; the live bus is ignored once an access starts.
    logic [1:0]    rwi_q;
    logic [1:0]    size_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          is_word;
    logic          is_half;
    logic          fault;
    logic          finish;
    logic          mem_we;
    logic [31:0]   cur_word;
    logic [31:0]   rd_fmt;
    logic [31:0]   wr_word;

    // Address decode and fault classification of the latched request.
    always_comb begin
        off     = addr_q - BASE_ADDR;
        idx     = off[AW+1:2];
        lane    = off[1:0];
        is_word = (rwi_q == RWI_FETCH) || size_q[1];
        is_half = !is_word && (size_q == 2'b01);
        fault   = (off >= SPAN) || (is_half && lane[0]) || (is_word && (lane != 2'b00));
        finish  = (state_q == S_BUSY) && (cnt_q == '0);
        mem_we  = finish && (rwi_q == RWI_WRITE) && !fault;
    end

    // Read formatting and read-modify-write merge of the addressed word.
    always_comb begin
        cur_word = mem[idx];
        // NOTE: every signal written in this always_comb gets a default first.
        // Without the default, an unassigned path would infer a latch.
        rd_fmt   = cur_word;
        wr_word  = cur_word;
        if (is_word) begin
            wr_word = wdata_q;
        end else if (is_half) begin
            rd_fmt = {16'h0000, cur_word[{lane[1], 4'b0000} +: 16]};
            wr_word[{lane[1], 4'b0000} +: 16] = wdata_q[15:0];
        end else begin
            rd_fmt = {24'h000000, cur_word[{lane, 3'b000} +: 8]};
            wr_word[{lane, 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    // Next-state and registered-output logic of the IDLE/BUSY/DONE handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        rdata_d = rdata_q;
        error_d = 1'b0;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (rwi_i != RWI_IDLE) begin
                    load    = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    busy_d  = 1'b0;
                    error_d = fault;
                    if (rwi_q[1]) begin
                        rdata_d = fault ? 32'h0 : rd_fmt;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, latched request and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
            rdata_q <= 32'h0;
            rwi_q   <= RWI_IDLE;
            size_q  <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments. All
            // registers then update together from pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            error_q <= error_d;
            rdata_q <= rdata_d;
            if (load) begin
                rwi_q   <= rwi_i;
                size_q  <= size_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end
        end
    end

    // SRAM write port; commits on the completing BUSY edge.
    // NOTE: the array has no reset. Clearing it would need a per-word reset
    // and would stop it mapping onto RAM. A reset during BUSY already clears
    // state_q, so mem_we stays low and the pending write is dropped.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= wr_word;
        end
    end

    assign busy_o  = busy_q;
    assign error_o = error_q;
    assign rdata_o = rdata_q;

`ifdef T07_MMIO_STATS_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;
    logic        rd_inc;
    logic        wr_inc;

    assign rd_inc = finish && rwi_q[1] && !fault;
    assign wr_inc = mem_we;

    // Saturating counts of good completed reads/fetches and writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q <= 16'h0000;
            wr_cnt_q <= 16'h0000;
        end else begin
            if (rd_inc && (rd_cnt_q != 16'hFFFF)) rd_cnt_q <= rd_cnt_q + 16'h0001;
            if (wr_inc && (wr_cnt_q != 16'hFFFF)) wr_cnt_q <= wr_cnt_q + 16'h0001;
        end
    end

    assign rd_count_o = rd_cnt_q;
    assign wr_count_o = wr_cnt_q;
`else
    assign rd_count_o = 16'h0000;
    assign wr_count_o = 16'h0000;
`endif

endmodule
